// File: rtl/mash_game_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mash_game_pkg : state encoding and timing/width constants            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mash_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READY     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_FAIL      = 3'd3,
    ST_ALL_CLEAR = 3'd4
  } state_e;

  localparam int TICKS_PER_SEC  = 1000;
  localparam int LEVEL_W        = 4;
  localparam int TLEFT_W        = 4;
  localparam int SEC_W          = $clog2(TICKS_PER_SEC);
  localparam int DEBOUNCE_TICKS = 10;

endpackage
`default_nettype wire

// File: rtl/mash_game_np_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mash_game_np_if : game control and status bundle                     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface mash_game_np_if #(
  parameter int NUM_PLAYERS    = 2,
  parameter int BTN_PER_PLAYER = 2,
  parameter int CNT_W          = 8
);
  import mash_game_pkg::*;

  logic                                    GAME_EN;
  logic [NUM_PLAYERS*BTN_PER_PLAYER-1:0]   BTN;
  logic [2:0]                              STATE;
  logic [LEVEL_W-1:0]                      LEVEL;
  logic [CNT_W-1:0]                        TARGET;
  logic [NUM_PLAYERS*CNT_W-1:0]            PRESS_CNT;
  logic [NUM_PLAYERS-1:0]                  WINNER;
  logic [TLEFT_W-1:0]                      TIME_LEFT_S;

  modport master (
    output GAME_EN, BTN,
    input  STATE, LEVEL, TARGET, PRESS_CNT, WINNER, TIME_LEFT_S
  );

  modport slave (
    input  GAME_EN, BTN,
    output STATE, LEVEL, TARGET, PRESS_CNT, WINNER, TIME_LEFT_S
  );
endinterface
`default_nettype wire

// File: rtl/mash_btn_cond.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mash_btn_cond : 2-flop sync, optional debounce (MASH_DEBOUNCE_EN),   |
// | rising-edge detect for one raw button.                  Rev 1.0      |
// +----------------------------------------------------------------------+
module mash_btn_cond
  import mash_game_pkg::*;
(
  input  wire logic CLK,
  input  wire logic RESETN,
  input  wire logic btn_i,
  output logic      level_o,
  output logic      edge_o
);

  logic sync1_q, sync2_q, prev_q;
  logic cond;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef MASH_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEBOUNCE_TICKS + 1);

  logic             deb_q;
  logic [DEB_W-1:0] stab_q;

  // Level follows the synchronised input only after it has disagreed for a full window.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      deb_q  <= 1'b0;
      stab_q <= '0;
    end else if (sync2_q == deb_q) begin
      stab_q <= '0;
    end else if (stab_q == DEB_W'(DEBOUNCE_TICKS - 1)) begin
      deb_q  <= sync2_q;
      stab_q <= '0;
    end else begin
      stab_q <= stab_q + 1'b1;
    end
  end

  assign cond = deb_q;
`else
  assign cond = sync2_q;
`endif

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) prev_q <= 1'b0;
    else         prev_q <= cond;
  end

  assign level_o = cond;
  assign edge_o  = cond & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/mash_game_np.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mash_game_np : multi-player button-mash level game (MASH_DEBOUNCE_EN |
// | enables button debounce in mash_btn_cond).              Rev 1.0      |
// +----------------------------------------------------------------------+
module mash_game_np
  import mash_game_pkg::*;
#(
  parameter int NUM_PLAYERS    = 2,
  parameter int BTN_PER_PLAYER = 2,
  parameter int NUM_LEVELS     = 5,
  parameter int TARGET_STEP    = 10,
  parameter int READY_TICKS    = 3000,
  parameter int PLAY_TICKS     = 5000,
  parameter int CNT_W          = 8
)(
  input  wire logic       CLK,
  input  wire logic       RESETN,
  mash_game_np_if.slave   bus
);

  localparam int NB     = NUM_PLAYERS * BTN_PER_PLAYER;
  localparam int TICK_W = $clog2(((READY_TICKS > PLAY_TICKS) ? READY_TICKS : PLAY_TICKS) + 1);
  localparam logic [TLEFT_W-1:0] READY_S = TLEFT_W'(READY_TICKS / TICKS_PER_SEC);
  localparam logic [TLEFT_W-1:0] PLAY_S  = TLEFT_W'(PLAY_TICKS / TICKS_PER_SEC);

  logic [NB-1:0] cond_lvl, btn_edge;

  for (genvar b = 0; b < NB; b++) begin : g_btn
    mash_btn_cond u_cond (
      .CLK     (CLK),
      .RESETN  (RESETN),
      .btn_i   (bus.BTN[b]),
      .level_o (cond_lvl[b]),
      .edge_o  (btn_edge[b])
    );
  end

  state_e                                state_q;
  logic [LEVEL_W-1:0]                    level_q;
  logic [NUM_PLAYERS-1:0][CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_PLAYERS-1:0]                winner_q, hit;
  logic [TICK_W-1:0]                     tick_q;
  logic [SEC_W-1:0]                      sec_q;
  logic [TLEFT_W-1:0]                    tleft_q;
  logic [CNT_W-1:0]                      target;

  assign target = CNT_W'(TARGET_STEP * level_q);

  // Counts including this cycle's press, so a clear is judged on the updated total.
  always_comb begin
    cnt_d = cnt_q;
    hit   = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if ((|btn_edge[p*BTN_PER_PLAYER +: BTN_PER_PLAYER]) && (cnt_q[p] != {CNT_W{1'b1}}))
        cnt_d[p] = cnt_q[p] + 1'b1;
      hit[p] = (cnt_d[p] >= target);
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN || !bus.GAME_EN) begin
      state_q  <= ST_IDLE;
      level_q  <= LEVEL_W'(1);
      cnt_q    <= '0;
      winner_q <= '0;
      tick_q   <= '0;
      sec_q    <= '0;
      tleft_q  <= '0;
    end else begin
      // Shared countdown; state transitions below override these on entry.
      if (state_q == ST_READY || state_q == ST_PLAY) begin
        tick_q <= tick_q + 1'b1;
        if (sec_q == SEC_W'(TICKS_PER_SEC - 1)) begin
          sec_q <= '0;
          if (tleft_q != '0) tleft_q <= tleft_q - 1'b1;
        end else begin
          sec_q <= sec_q + 1'b1;
        end
      end

      case (state_q)
        ST_IDLE, ST_FAIL, ST_ALL_CLEAR: begin
          if (state_q == ST_IDLE || (&cond_lvl)) begin
            state_q  <= ST_READY;
            level_q  <= LEVEL_W'(1);
            cnt_q    <= '0;
            winner_q <= '0;
            tick_q   <= '0;
            sec_q    <= '0;
            tleft_q  <= READY_S;
          end
        end
        ST_READY: begin
          if (tick_q == TICK_W'(READY_TICKS - 1)) begin
            state_q <= ST_PLAY;
            tick_q  <= '0;
            sec_q   <= '0;
            tleft_q <= PLAY_S;
          end
        end
        ST_PLAY: begin
          cnt_q <= cnt_d;
          if (|hit) begin
            winner_q <= hit;
            if (level_q == LEVEL_W'(NUM_LEVELS)) begin
              state_q <= ST_ALL_CLEAR;
              tleft_q <= '0;
            end else begin
              state_q <= ST_READY;
              level_q <= level_q + 1'b1;
              cnt_q   <= '0;
              tick_q  <= '0;
              sec_q   <= '0;
              tleft_q <= READY_S;
            end
          end else if (tick_q == TICK_W'(PLAY_TICKS - 1)) begin
            state_q  <= ST_FAIL;
            level_q  <= LEVEL_W'(1);
            winner_q <= '0;
            tleft_q  <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.STATE       = state_q;
  assign bus.LEVEL       = level_q;
  assign bus.TARGET      = target;
  assign bus.PRESS_CNT   = cnt_q;
  assign bus.WINNER      = winner_q;
  assign bus.TIME_LEFT_S = tleft_q;

endmodule
`default_nettype wire

// File: tb/tb_mash_game_np.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mash_game_np : randomized scenario bench with press-arrival model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_mash_game_np;
  import mash_game_pkg::*;

  localparam int NP = 2, BPP = 2, NB = NP * BPP, CW = 8;
  localparam int NL = 5, TS = 10, RT = 3000, PT = 5000;
`ifdef MASH_DEBOUNCE_EN
  localparam int DEB = DEBOUNCE_TICKS, PH = 20, PL = 20;
`else
  localparam int DEB = 0, PH = 1, PL = 1;
`endif
  // A press driven after edge d becomes a count on edge d+LAT.
  localparam int LAT   = 3 + DEB;
  localparam int DRV_N = PT + 64;

  logic CLK = 1'b0;
  logic RESETN = 1'b0;
  always #5 CLK = ~CLK;

  mash_game_np_if #(.NUM_PLAYERS(NP), .BTN_PER_PLAYER(BPP), .CNT_W(CW)) bus ();

  mash_game_np #(
    .NUM_PLAYERS(NP), .BTN_PER_PLAYER(BPP), .NUM_LEVELS(NL), .TARGET_STEP(TS),
    .READY_TICKS(RT), .PLAY_TICKS(PT), .CNT_W(CW)
  ) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int m_level = 1;
  logic [NB-1:0] drv [DRV_N];
  bit            prs [NP][DRV_N];

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic clear_sched();
    for (int d = 0; d < DRV_N; d++) begin
      drv[d] = '0;
      for (int p = 0; p < NP; p++) prs[p][d] = 1'b0;
    end
  endtask

  task automatic gen_presses(input int p, input int n, input int lo, input int gapmax);
    int d;
    logic [BPP-1:0] m;
    d = lo + $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      m = BPP'($urandom_range(1, (1 << BPP) - 1));
      prs[p][d] = 1'b1;
      for (int k = 0; k < PH; k++) drv[d+k][p*BPP +: BPP] = m;
      d += PH + PL + $urandom_range(0, gapmax);
    end
  endtask

  // Runs one PLAY window from the schedule and checks against press-arrival counting.
  task automatic play_and_check(input string tag);
    int cnt [NP];
    int tgt, e, es, el;
    bit done;
    bit [NP-1:0] win;
    tgt  = TS * m_level;
    done = 1'b0;
    for (int p = 0; p < NP; p++) cnt[p] = 0;
    for (int c = 0; c < PT && !done; c++) begin
      bus.BTN = drv[c];
      tick();
      e = c + 1;
      win = '0;
      for (int p = 0; p < NP; p++) begin
        if (e - LAT >= 0 && prs[p][e-LAT] && cnt[p] < 255) cnt[p]++;
        if (cnt[p] >= tgt) win[p] = 1'b1;
      end
      if (win != '0) begin
        done = 1'b1;
        es = (m_level < NL) ? 1 : 4;
        el = (m_level < NL) ? m_level + 1 : NL;
        checks++; if (bus.STATE !== 3'(es)) begin errors++; $display("FAIL %s clear_state e=%0d got %0d want %0d", tag, e, bus.STATE, es); end
        checks++; if (bus.LEVEL !== 4'(el)) begin errors++; $display("FAIL %s clear_level got %0d want %0d", tag, bus.LEVEL, el); end
        checks++; if (bus.WINNER !== win) begin errors++; $display("FAIL %s clear_winner got %b want %b", tag, bus.WINNER, win); end
        checks++; if (bus.TARGET !== CW'(TS * el)) begin errors++; $display("FAIL %s clear_target got %0d want %0d", tag, bus.TARGET, TS * el); end
        if (es == 1) begin
          checks++; if (bus.PRESS_CNT !== '0) begin errors++; $display("FAIL %s clear_cnt got %h want 0", tag, bus.PRESS_CNT); end
          checks++; if (bus.TIME_LEFT_S !== 4'(RT / 1000)) begin errors++; $display("FAIL %s clear_time got %0d want %0d", tag, bus.TIME_LEFT_S, RT / 1000); end
        end
        m_level = el;
      end else if (e == PT) begin
        done = 1'b1;
        checks++; if (bus.STATE !== 3'd3) begin errors++; $display("FAIL %s timeout_state got %0d want 3", tag, bus.STATE); end
        checks++; if (bus.LEVEL !== 4'd1) begin errors++; $display("FAIL %s timeout_level got %0d want 1", tag, bus.LEVEL); end
        checks++; if (bus.WINNER !== '0) begin errors++; $display("FAIL %s timeout_winner got %b want 0", tag, bus.WINNER); end
        checks++; if (bus.TIME_LEFT_S !== 4'd0) begin errors++; $display("FAIL %s timeout_time got %0d want 0", tag, bus.TIME_LEFT_S); end
        checks++; if (bus.TARGET !== CW'(TS)) begin errors++; $display("FAIL %s timeout_target got %0d want %0d", tag, bus.TARGET, TS); end
        m_level = 1;
      end else begin
        checks++; if (bus.STATE !== 3'd2) begin errors++; $display("FAIL %s play_state e=%0d got %0d want 2", tag, e, bus.STATE); end
        for (int p = 0; p < NP; p++) begin
          checks++; if (bus.PRESS_CNT[p*CW +: CW] !== CW'(cnt[p])) begin errors++; $display("FAIL %s play_cnt p=%0d e=%0d got %0d want %0d", tag, p, e, bus.PRESS_CNT[p*CW +: CW], cnt[p]); end
        end
        if (e % 1000 == 0 || e % 1000 == 999) begin
          checks++; if (bus.TIME_LEFT_S !== 4'(PT / 1000 - e / 1000)) begin errors++; $display("FAIL %s play_time e=%0d got %0d want %0d", tag, e, bus.TIME_LEFT_S, PT / 1000 - e / 1000); end
        end
      end
    end
    bus.BTN = '0;
  endtask

  task automatic test_reset();
    RESETN = 1'b0; bus.GAME_EN = 1'b0; bus.BTN = '1;
    tick(); tick();
    checks++; if (bus.STATE !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus.STATE); end
    checks++; if (bus.LEVEL !== 4'd1) begin errors++; $display("FAIL reset_level got %0d want 1", bus.LEVEL); end
    checks++; if (bus.TARGET !== CW'(TS)) begin errors++; $display("FAIL reset_target got %0d want %0d", bus.TARGET, TS); end
    checks++; if (bus.PRESS_CNT !== '0) begin errors++; $display("FAIL reset_cnt got %h want 0", bus.PRESS_CNT); end
    checks++; if (bus.WINNER !== '0) begin errors++; $display("FAIL reset_winner got %b want 0", bus.WINNER); end
    checks++; if (bus.TIME_LEFT_S !== 4'd0) begin errors++; $display("FAIL reset_time got %0d want 0", bus.TIME_LEFT_S); end
    RESETN = 1'b1;
    repeat (5) tick();
    checks++; if (bus.STATE !== 3'd0) begin errors++; $display("FAIL idle_hold got %0d want 0", bus.STATE); end
    bus.BTN = '0;
    repeat (20 + DEB) tick();
    m_level = 1;
    bus.GAME_EN = 1'b1;
    tick();
  endtask

  // Entered just after the READY-entry edge; returns just after the PLAY-entry edge.
  task automatic test_ready();
    checks++; if (bus.STATE !== 3'd1) begin errors++; $display("FAIL ready_entry_state got %0d want 1", bus.STATE); end
    checks++; if (bus.TIME_LEFT_S !== 4'(RT / 1000)) begin errors++; $display("FAIL ready_entry_time got %0d want %0d", bus.TIME_LEFT_S, RT / 1000); end
    checks++; if (bus.LEVEL !== 4'(m_level)) begin errors++; $display("FAIL ready_level got %0d want %0d", bus.LEVEL, m_level); end
    for (int k = 1; k <= RT; k++) begin
      bus.BTN = (k < RT - 100 && $urandom_range(0, 7) == 0) ? NB'($urandom) : '0;
      tick();
      if (k < RT && (k % 1000 == 0 || k % 1000 == 999)) begin
        checks++; if (bus.TIME_LEFT_S !== 4'(RT / 1000 - k / 1000)) begin errors++; $display("FAIL ready_time k=%0d got %0d want %0d", k, bus.TIME_LEFT_S, RT / 1000 - k / 1000); end
      end
      if (k == RT - 1) begin
        checks++; if (bus.STATE !== 3'd1) begin errors++; $display("FAIL ready_last_state got %0d want 1", bus.STATE); end
        checks++; if (bus.PRESS_CNT !== '0) begin errors++; $display("FAIL ready_cnt got %h want 0", bus.PRESS_CNT); end
      end
    end
    bus.BTN = '0;
    checks++; if (bus.STATE !== 3'd2) begin errors++; $display("FAIL play_entry_state got %0d want 2", bus.STATE); end
    checks++; if (bus.TIME_LEFT_S !== 4'(PT / 1000)) begin errors++; $display("FAIL play_entry_time got %0d want %0d", bus.TIME_LEFT_S, PT / 1000); end
    checks++; if (bus.TARGET !== CW'(TS * m_level)) begin errors++; $display("FAIL play_entry_target got %0d want %0d", bus.TARGET, TS * m_level); end
  endtask

  task automatic test_single_winner();
    clear_sched();
    gen_presses(0, TS * m_level, 0, 6);
    gen_presses(1, TS * m_level / 2, 0, 6);
    play_and_check("single");
  endtask

  task automatic test_dual_winner();
    logic [BPP-1:0] m1;
    clear_sched();
    gen_presses(0, TS * m_level, 0, 4);
    m1 = BPP'($urandom_range(1, (1 << BPP) - 1));
    for (int d = 0; d < DRV_N; d++) begin
      prs[1][d] = prs[0][d];
      if (drv[d][BPP-1:0] != '0) drv[d][BPP +: BPP] = m1;
    end
    play_and_check("dual");
  endtask

  task automatic test_timeout_fail();
    clear_sched();
    gen_presses(0, TS * m_level - 1, 0, 8);
    gen_presses(1, TS * m_level / 2, 0, 8);
    play_and_check("fail");
  endtask

  task automatic test_timeout_edge_clear();
    int d;
    clear_sched();
    gen_presses(0, TS * m_level - 1, 0, 6);
    gen_presses(1, 5, 0, 6);
    d = PT - LAT;
    prs[0][d] = 1'b1;
    for (int k = 0; k < PH; k++) drv[d+k][0 +: BPP] = BPP'(1);
    play_and_check("edge");
  endtask

  task automatic test_random_clear();
    int w, tgt;
    clear_sched();
    tgt = TS * m_level;
    w = $urandom_range(0, NP - 1);
    for (int p = 0; p < NP; p++)
      gen_presses(p, (p == w) ? tgt : $urandom_range(tgt - 5, tgt), 0, 4);
    play_and_check("random");
  endtask

  task automatic test_restart(input string tag, input int from_state);
    checks++; if (bus.STATE !== 3'(from_state)) begin errors++; $display("FAIL %s pre_state got %0d want %0d", tag, bus.STATE, from_state); end
    bus.BTN = NB'((1 << (NB - 1)) - 1);
    repeat (20 + DEB) tick();
    checks++; if (bus.STATE !== 3'(from_state)) begin errors++; $display("FAIL %s partial_hold got %0d want %0d", tag, bus.STATE, from_state); end
    bus.BTN = '1;
    repeat (LAT - 1) tick();
    checks++; if (bus.STATE !== 3'(from_state)) begin errors++; $display("FAIL %s early_exit got %0d want %0d", tag, bus.STATE, from_state); end
    tick();
    bus.BTN = '0;
    m_level = 1;
    checks++; if (bus.STATE !== 3'd1) begin errors++; $display("FAIL %s restart_state got %0d want 1", tag, bus.STATE); end
    checks++; if (bus.WINNER !== '0) begin errors++; $display("FAIL %s restart_winner got %b want 0", tag, bus.WINNER); end
    checks++; if (bus.PRESS_CNT !== '0) begin errors++; $display("FAIL %s restart_cnt got %h want 0", tag, bus.PRESS_CNT); end
    checks++; if (bus.TARGET !== CW'(TS)) begin errors++; $display("FAIL %s restart_target got %0d want %0d", tag, bus.TARGET, TS); end
  endtask

  task automatic test_game_en_drop();
`ifdef MASH_DEBOUNCE_EN
    for (int g = 0; g < 3; g++) begin
      bus.BTN = NB'(1); repeat (5) tick();
      bus.BTN = '0;     repeat (15) tick();
    end
    checks++; if (bus.PRESS_CNT[0 +: CW] !== CW'(0)) begin errors++; $display("FAIL glitch_cnt got %0d want 0", bus.PRESS_CNT[0 +: CW]); end
    bus.BTN = NB'(1); repeat (20) tick();
    bus.BTN = '0;     repeat (40) tick();
    checks++; if (bus.PRESS_CNT[0 +: CW] !== CW'(1)) begin errors++; $display("FAIL long_pulse_cnt got %0d want 1", bus.PRESS_CNT[0 +: CW]); end
`else
    int exp0;
    clear_sched();
    gen_presses(0, 5, 0, 6);
    gen_presses(1, 3, 0, 6);
    exp0 = 0;
    for (int c = 0; c < 60; c++) begin
      bus.BTN = drv[c];
      tick();
    end
    for (int d = 0; d + LAT <= 60; d++) if (prs[0][d]) exp0++;
    checks++; if (bus.PRESS_CNT[0 +: CW] !== CW'(exp0)) begin errors++; $display("FAIL drop_pre_cnt got %0d want %0d", bus.PRESS_CNT[0 +: CW], exp0); end
`endif
    bus.BTN = '0;
    bus.GAME_EN = 1'b0;
    tick();
    checks++; if (bus.STATE !== 3'd0) begin errors++; $display("FAIL drop_state got %0d want 0", bus.STATE); end
    checks++; if (bus.PRESS_CNT !== '0) begin errors++; $display("FAIL drop_cnt got %h want 0", bus.PRESS_CNT); end
    checks++; if (bus.LEVEL !== 4'd1) begin errors++; $display("FAIL drop_level got %0d want 1", bus.LEVEL); end
    checks++; if (bus.TIME_LEFT_S !== 4'd0) begin errors++; $display("FAIL drop_time got %0d want 0", bus.TIME_LEFT_S); end
    checks++; if (bus.WINNER !== '0) begin errors++; $display("FAIL drop_winner got %b want 0", bus.WINNER); end
    tick();
    checks++; if (bus.STATE !== 3'd0) begin errors++; $display("FAIL drop_hold got %0d want 0", bus.STATE); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.GAME_EN = 1'b0;
    bus.BTN     = '0;
    test_reset();
    test_ready();
    test_single_winner();
    test_ready();
    test_dual_winner();
    test_ready();
    test_timeout_fail();
    test_restart("fail", 3);
    test_ready();
    test_timeout_edge_clear();
    for (int l = 2; l <= NL; l++) begin
      test_ready();
      test_random_clear();
    end
    test_restart("allclear", 4);
    test_ready();
    test_game_en_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mash_game_np.md
MASH_GAME_NP -- requirements
Module: mash_game_np

Interface
REQ-001 Parameter NUM_PLAYERS, 2, number of independent players (1..4).
REQ-002 Parameter BTN_PER_PLAYER, 2, buttons per player.
REQ-003 Parameter NUM_LEVELS, 5, levels before ALL_CLEAR (1..15).
REQ-004 Parameter TARGET_STEP, 10, presses required per level unit (TARGET = TARGET_STEP*LEVEL).
REQ-005 Parameters READY_TICKS 3000 and PLAY_TICKS 5000, countdown and play windows in CLK cycles; both SHALL be multiples of TICKS_PER_SEC (1000).
REQ-006 Parameter CNT_W, 8, width of each press counter and of TARGET.
REQ-007 CLK  in  1  1 kHz game clock, one tick per cycle; RESETN  in  1  asynchronous, active-low reset.
REQ-008 GAME_EN  in  1  game selected; low forces IDLE.
REQ-009 BTN  in  NUM_PLAYERS*BTN_PER_PLAYER  raw buttons, player p owns bits [p*BTN_PER_PLAYER +: BTN_PER_PLAYER].
REQ-010 STATE  out  3  IDLE=0, READY=1, PLAY=2, FAIL=3, ALL_CLEAR=4.
REQ-011 LEVEL  out  4  current level; TARGET  out  CNT_W  current target.
REQ-012 PRESS_CNT  out  NUM_PLAYERS*CNT_W  per-player press counts, player p at [p*CNT_W +: CNT_W].
REQ-013 WINNER  out  NUM_PLAYERS  one-hot/multi-hot players who cleared the last level; TIME_LEFT_S  out  4  whole seconds remaining.

Function
REQ-014 Each BTN bit SHALL pass through a 2-flop synchroniser, then a rising-edge detector; a press is counted on the 3rd rising CLK edge after BTN rises.
REQ-015 A player's counter SHALL increment by at most 1 per cycle when any of its buttons shows an edge, and SHALL saturate at 2^CNT_W-1.
REQ-016 IDLE -> READY when GAME_EN high; LEVEL=1, all counters and WINNER cleared.
REQ-017 READY: counts READY_TICKS cycles, counters held at 0, presses ignored; then -> PLAY with tick counter 0.
REQ-018 PLAY: tick counter increments each cycle; if any player's count (including this cycle's increment) >= TARGET, WINNER latches all such players and the block leaves PLAY.
REQ-019 Level clear with LEVEL<NUM_LEVELS -> READY, LEVEL+1; with LEVEL==NUM_LEVELS -> ALL_CLEAR, LEVEL held.
REQ-020 Tick counter reaching PLAY_TICKS without a clear -> FAIL, LEVEL=1, WINNER=0.
REQ-021 Simultaneous target reach and timeout on the same cycle SHALL resolve as a clear.
REQ-022 FAIL/ALL_CLEAR: hold until every conditioned BTN bit is high on one cycle, then -> READY with LEVEL=1, counters and WINNER cleared.
REQ-023 TIME_LEFT_S SHALL load READY_TICKS/1000 or PLAY_TICKS/1000 on state entry and decrement each 1000 ticks; 0 in IDLE/FAIL/ALL_CLEAR.
REQ-024 GAME_EN low in any state SHALL force IDLE on the next edge with all outputs at reset values.

Reset
REQ-025 RESETN low SHALL asynchronously set STATE=IDLE, LEVEL=1, TARGET=TARGET_STEP, PRESS_CNT=0, WINNER=0, TIME_LEFT_S=0, all synchroniser, edge and tick flops 0.
REQ-026 After RESETN release, the first edge SHALL be processed normally; no press is counted from buttons held through reset.

Configuration
REQ-027 Macro MASH_DEBOUNCE_EN defined: each synchronised button SHALL be stable for DEBOUNCE_TICKS (default 10) consecutive cycles before its conditioned level changes, adding DEBOUNCE_TICKS cycles of latency.
REQ-028 MASH_DEBOUNCE_EN undefined: conditioned level equals synchronised level, no debounce logic present.

Structure
REQ-029 Package mash_game_pkg SHALL hold the state encoding, TICKS_PER_SEC, and level width constants.
REQ-030 Sub-module mash_btn_cond (synchroniser, optional debounce, edge detect) SHALL be instantiated once per button.

Verification
REQ-031 Reset then GAME_EN=1 -> STATE=1, TIME_LEFT_S=3; after 3000 cycles STATE=2, TIME_LEFT_S=5, TARGET=10.
REQ-032 Player 0 gives 10 pulses within 5000 ticks -> WINNER=01, STATE=1, LEVEL=2, TARGET=20.
REQ-033 Both players reach 10 on the same cycle -> WINNER=11; 9 presses only by tick 5000 -> STATE=3, LEVEL=1.
REQ-034 10th press lands on the timeout cycle -> clear, not FAIL; clear at level 5 -> STATE=4, LEVEL=5.
REQ-035 In FAIL hold all 4 BTN high -> STATE=1, LEVEL=1; GAME_EN dropped mid-PLAY -> STATE=0, PRESS_CNT=0 next cycle.
REQ-036 With MASH_DEBOUNCE_EN, 5-cycle glitch pulses -> no count; 20-cycle pulse -> exactly 1 count.
